// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the 27-channel interrupt priority scheduler.
package irq_sched_pkg;

    localparam int NCH_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        OFFER   = 2'd2,
        SERVICE = 2'd3
    } state_t;

    localparam logic [1:0] BUS_A    = 2'd0;
    localparam logic [1:0] BUS_B    = 2'd1;
    localparam logic [1:0] BUS_C    = 2'd2;
    localparam logic [1:0] BUS_NONE = 2'd3;

    localparam logic [3:0] CH_NONE = 4'hF;

endpackage

// File: rtl/irq_prio_resolve.sv
// Combinational fixed-priority resolver: bus A > B > C, channel 0 highest within a bus.
module irq_prio_resolve
    import irq_sched_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT
) (
    input  logic [NCH-1:0] elig_a,
    input  logic [NCH-1:0] elig_b,
    input  logic [NCH-1:0] elig_c,
    output logic [1:0]     bus,
    output logic [3:0]     ch,
    output logic           any
);

    // Scan lowest priority first so higher-priority hits overwrite earlier ones.
    always_comb begin
        bus = BUS_NONE;
        ch  = CH_NONE;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig_c[i]) begin
                bus = BUS_C;
                ch  = 4'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig_b[i]) begin
                bus = BUS_B;
                ch  = 4'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (elig_a[i]) begin
                bus = BUS_A;
                ch  = 4'(i);
            end
        end
        any = |{elig_a, elig_b, elig_c};
    end

endmodule

// File: rtl/irq_priority_sched.sv
// Interrupt scheduler front end: edge capture, shared enable mask, grant handshake, EOI hold-off.
// Optional EOI timeout enabled by defining IRQ_SCHED_EOI_TIMEOUT_EN.
module irq_priority_sched
    import irq_sched_pkg::*;
#(
    parameter int NCH         = NCH_DEFAULT,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic           mask_we,
    input  logic [NCH-1:0] mask_wdata,
    output logic           grant_valid,
    input  logic           grant_ready,
    output logic [1:0]     grant_bus,
    output logic [3:0]     grant_ch,
    input  logic           eoi,
    output logic           in_service,
    output logic [2:0]     pend_any,
    output logic           eoi_timeout
);

    state_t                state_q, state_d;
    logic [2:0][NCH-1:0]   req_q, req_d;
    logic [2:0][NCH-1:0]   pend_q, pend_d;
    logic [2:0][NCH-1:0]   elig, clr, rise;
    logic [NCH-1:0]        mask_q, mask_d;
    logic [2:0]            pend_any_q, pend_any_d;
    logic [1:0]            grant_bus_q, grant_bus_d;
    logic [3:0]            grant_ch_q, grant_ch_d;
    logic [1:0]            res_bus;
    logic [3:0]            res_ch;
    logic                  res_any;
    logic                  handshake;
    logic                  timeout_hit;

    // Capture and mask datapath; a new rising edge beats a same-cycle handshake clear.
    always_comb begin
        req_d     = {req_c, req_b, req_a};
        rise      = req_d & ~req_q;
        handshake = (state_q == OFFER) && grant_ready;
        clr       = '0;
        for (int b = 0; b < 3; b++) begin
            elig[b] = pend_q[b] & mask_q;
            for (int i = 0; i < NCH; i++) begin
                clr[b][i] = handshake && (grant_bus_q == 2'(b)) && (grant_ch_q == 4'(i));
            end
        end
        pend_d     = (pend_q & ~clr) | rise;
        mask_d     = mask_we ? mask_wdata : mask_q;
        pend_any_d = {|elig[2], |elig[1], |elig[0]};
    end

    irq_prio_resolve #(.NCH(NCH)) u_resolve (
        .elig_a (elig[0]),
        .elig_b (elig[1]),
        .elig_c (elig[2]),
        .bus    (res_bus),
        .ch     (res_ch),
        .any    (res_any)
    );

`ifdef IRQ_SCHED_EOI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eoi_timeout_q, eoi_timeout_d;

    // Counter restarts from zero on every entry to SERVICE.
    always_comb begin
        cnt_d         = (state_q == SERVICE) ? cnt_q + 1'b1 : '0;
        timeout_hit   = (state_q == SERVICE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        eoi_timeout_d = timeout_hit && !eoi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            eoi_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            eoi_timeout_q <= eoi_timeout_d;
        end
    end

    assign eoi_timeout = eoi_timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_hit        = 1'b0;
    assign eoi_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '1;
            pend_any_q  <= '0;
            grant_bus_q <= BUS_NONE;
            grant_ch_q  <= CH_NONE;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            pend_any_q  <= pend_any_d;
            grant_bus_q <= grant_bus_d;
            grant_ch_q  <= grant_ch_d;
        end
    end

    // The vector is latched only in ARB, so a live offer never changes.
    always_comb begin
        state_d     = state_q;
        grant_bus_d = grant_bus_q;
        grant_ch_d  = grant_ch_q;
        unique case (state_q)
            IDLE:    if (res_any) state_d = ARB;
            ARB: begin
                grant_bus_d = res_bus;
                grant_ch_d  = res_ch;
                state_d     = res_any ? OFFER : IDLE;
            end
            OFFER:   if (grant_ready) state_d = SERVICE;
            SERVICE: if (eoi || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_valid = (state_q == OFFER);
        in_service  = (state_q == SERVICE);
    end

    assign grant_bus = grant_bus_q;
    assign grant_ch  = grant_ch_q;
    assign pend_any  = pend_any_q;

endmodule
